// File: rtl/riscv_pkg.sv
// Shared constants and types for the RV32I register unit and its dump controller.
// Latency: none; this file holds declarations only.
// Backpressure: not applicable.
package riscv_pkg;

    localparam int XLEN     = 32;
    localparam int NUM_REGS = 32;

    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam logic [4:0] REG_SP   = 5'd2;
    localparam logic [4:0] REG_LAST = 5'(NUM_REGS - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } dump_state_t;

endpackage

// File: rtl/ru_dump_ctrl.sv
// Dump sequencer: walks register indices 0..31 once per dump request.
// Latency: first beat is valid the cycle after dump_req; one beat per accepted handshake.
// Backpressure: dump_ready low holds dump_idx/dump_valid stable; requests while busy are dropped.
module ru_dump_ctrl
    import riscv_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       dump_req,
    input  logic       dump_ready,
    output logic       dump_valid,
    output logic       dump_busy,
    output logic [4:0] dump_idx
);

    dump_state_t state, state_nxt;
    logic [4:0]  idx, idx_nxt;

    // State and beat index register; reset returns to IDLE with index 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
        end
    end

    // Next-state and handshake outputs; the last accepted beat ends the dump.
    always_comb begin
        state_nxt  = state;
        idx_nxt    = idx;
        dump_valid = 1'b0;
        dump_busy  = 1'b0;
        case (state)
            IDLE: begin
                if (dump_req) begin
                    state_nxt = SEND;
                    idx_nxt   = '0;
                end
            end
            SEND: begin
                dump_valid = 1'b1;
                dump_busy  = 1'b1;
                if (dump_ready) begin
                    if (idx == REG_LAST) begin
                        state_nxt = IDLE;
                        idx_nxt   = '0;
                    end else begin
                        idx_nxt = idx + 5'd1;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                idx_nxt   = '0;
            end
        endcase
    end

    assign dump_idx = idx;

endmodule

// File: rtl/register_unit.sv
// 32 x XLEN RV32I register file with two combinational read ports and a debug dump stream.
// Latency: reads are zero-cycle; writes land on the clock edge; dump emits one beat per handshake.
// Backpressure: dump beats hold while dump_ready is low; the operand path never stalls.
module register_unit
    import riscv_pkg::*;
#(
    parameter int             XLEN    = riscv_pkg::XLEN,
    parameter logic [XLEN-1:0] SP_INIT = 'h0000_1000,
    parameter bit             BYPASS  = 1'b0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            RUWr,
    input  logic [4:0]      rd,
    input  logic [XLEN-1:0] DataWr,
    input  logic [4:0]      rs1,
    input  logic [4:0]      rs2,
    output logic [XLEN-1:0] RU_rs1,
    output logic [XLEN-1:0] RU_rs2,
    input  logic            dump_req,
    output logic            dump_valid,
    input  logic            dump_ready,
    output logic [4:0]      dump_idx,
    output logic [XLEN-1:0] dump_data,
    output logic            dump_busy
);

    // x0 is kept in the array but never written, so every read of index 0 is 0.
    logic [XLEN-1:0] regs [NUM_REGS];
    logic            wr_hit;

    assign wr_hit = RUWr && (rd != REG_ZERO);

    // Register array: async clear (sp gets its boot value), then write-back updates.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= (i == int'(REG_SP)) ? SP_INIT : '0;
            end
        end else if (wr_hit) begin
            regs[rd] <= DataWr;
        end
    end

    // Operand reads; the optional bypass forwards same-cycle write data.
    always_comb begin
        RU_rs1 = regs[rs1];
        RU_rs2 = regs[rs2];
        if (BYPASS && wr_hit && (rs1 == rd)) RU_rs1 = DataWr;
        if (BYPASS && wr_hit && (rs2 == rd)) RU_rs2 = DataWr;
    end

    ru_dump_ctrl u_dump_ctrl (
        .clk        (clk),
        .rst        (rst),
        .dump_req   (dump_req),
        .dump_ready (dump_ready),
        .dump_valid (dump_valid),
        .dump_busy  (dump_busy),
        .dump_idx   (dump_idx)
    );

    // The dump path shows stored contents only, never in-flight write data.
    assign dump_data = regs[dump_idx];

endmodule

// File: tb/tb_register_unit.sv
// Directed bench for register_unit: reset, write/read, x0 protection, dump stream, reset mid-dump.
// Latency: samples one time unit after inputs settle, away from the rising edge.
// Backpressure: dump_ready toggles every other cycle during the main dump.
module tb_register_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        RUWr;
    logic [4:0]  rd;
    logic [31:0] DataWr;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] RU_rs1;
    logic [31:0] RU_rs2;
    logic        dump_req;
    logic        dump_valid;
    logic        dump_ready;
    logic [4:0]  dump_idx;
    logic [31:0] dump_data;
    logic        dump_busy;

    typedef struct {
        logic [4:0]  idx;
        logic [31:0] data;
    } beat_t;

    beat_t       sb [$];
    beat_t       exp_beat;
    logic [31:0] model [32];
    int          n_checks = 0;
    int          n_fail   = 0;

    register_unit dut (
        .clk        (clk),
        .rst        (rst),
        .RUWr       (RUWr),
        .rd         (rd),
        .DataWr     (DataWr),
        .rs1        (rs1),
        .rs2        (rs2),
        .RU_rs1     (RU_rs1),
        .RU_rs2     (RU_rs2),
        .dump_req   (dump_req),
        .dump_valid (dump_valid),
        .dump_ready (dump_ready),
        .dump_idx   (dump_idx),
        .dump_data  (dump_data),
        .dump_busy  (dump_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Bench-side write: drives one write cycle and mirrors it in the model.
    task automatic write_reg(input logic [4:0] r, input logic [31:0] d);
        RUWr   = 1'b1;
        rd     = r;
        DataWr = d;
        tick();
        if (r != 5'd0) model[r] = d;
        RUWr = 1'b0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
        model[2] = 32'h0000_1000;
    endtask

    initial begin
        int  beats;
        int  cyc;
        bit  last;
        bit  req_sent;
        bit  hs;

        rst        = 1'b1;
        RUWr       = 1'b0;
        rd         = 5'd0;
        DataWr     = 32'h0;
        rs1        = 5'd2;
        rs2        = 5'd5;
        dump_req   = 1'b0;
        dump_ready = 1'b0;
        model_reset();

        // Reset state
        #2;
        check("reset_sp", RU_rs1, 32'h0000_1000);
        check("reset_x5", RU_rs2, 32'h0);
        check("reset_busy", {31'h0, dump_busy}, 32'h0);
        check("reset_valid", {31'h0, dump_valid}, 32'h0);
        check("reset_idx", {27'h0, dump_idx}, 32'h0);
        tick();
        rst = 1'b0;
        tick();

        // Write then read x5; old value is visible during the write cycle
        RUWr   = 1'b1;
        rd     = 5'd5;
        DataWr = 32'hCAFE_BABE;
        rs1    = 5'd5;
        #1;
        check("wr_before_edge", RU_rs1, 32'h0);
        tick();
        model[5] = 32'hCAFE_BABE;
        RUWr = 1'b0;
        #1;
        check("wr_after_edge", RU_rs1, 32'hCAFE_BABE);
        rs2 = 5'd5;
        #1;
        check("rd_port2_x5", RU_rs2, 32'hCAFE_BABE);

        // x0 protection
        rs1 = 5'd0;
        write_reg(5'd0, 32'h1234_5678);
        #1;
        check("x0_protect", RU_rs1, 32'h0);

        // Write disable
        RUWr   = 1'b0;
        rd     = 5'd7;
        DataWr = 32'hFFFF_FFFF;
        rs1    = 5'd7;
        tick();
        check("wr_disable_x7", RU_rs1, 32'h0);

        // Preload and dump with ready toggling every other cycle
        write_reg(5'd1, 32'h0000_0040);
        write_reg(5'd31, 32'hDEAD_BEEF);
        rs1 = 5'd1;
        rs2 = 5'd31;
        #1;
        check("preload_x1", RU_rs1, 32'h0000_0040);
        check("preload_x31", RU_rs2, 32'hDEAD_BEEF);

        dump_req = 1'b1;
        for (int i = 0; i < 32; i++) begin
            exp_beat.idx  = 5'(i);
            exp_beat.data = model[i];
            sb.push_back(exp_beat);
        end
        tick();
        dump_req = 1'b0;
        beats    = 0;
        last     = 1'b0;
        req_sent = 1'b0;
        for (cyc = 0; cyc < 200 && !last; cyc++) begin
            dump_ready = cyc[0];
            if (dump_idx == 5'd4 && !req_sent) begin
                dump_req = 1'b1;
                req_sent = 1'b1;
            end else begin
                dump_req = 1'b0;
            end
            #1;
            hs = dump_valid && dump_ready;
            if (hs) begin
                if (sb.size() == 0) begin
                    check("dump_extra_beat", {27'h0, dump_idx}, 32'hFFFF_FFFF);
                end else begin
                    exp_beat = sb.pop_front();
                    check("dump_idx", {27'h0, dump_idx}, {27'h0, exp_beat.idx});
                    check("dump_data", dump_data, exp_beat.data);
                    if (exp_beat.idx == 5'd1)  check("beat1_const", dump_data, 32'h0000_0040);
                    if (exp_beat.idx == 5'd2)  check("beat2_const", dump_data, 32'h0000_1000);
                    if (exp_beat.idx == 5'd31) begin
                        check("beat31_const", dump_data, 32'hDEAD_BEEF);
                        last = 1'b1;
                    end
                end
                beats++;
            end
            tick();
        end
        dump_ready = 1'b0;
        dump_req   = 1'b0;
        check("dump_req_seen", {31'h0, req_sent}, 32'h1);
        check("dump_beats", beats, 32);
        check("dump_sb_empty", sb.size(), 0);
        check("dump_busy_after", {31'h0, dump_busy}, 32'h0);
        check("dump_valid_after", {31'h0, dump_valid}, 32'h0);
        tick();
        check("dump_stays_idle", {31'h0, dump_busy}, 32'h0);

        // Reset in the middle of a dump
        dump_req = 1'b1;
        tick();
        dump_req   = 1'b0;
        dump_ready = 1'b1;
        for (cyc = 0; cyc < 100 && dump_idx != 5'd10; cyc++) tick();
        check("reach_idx10", {27'h0, dump_idx}, 32'd10);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check("mid_rst_valid", {31'h0, dump_valid}, 32'h0);
        check("mid_rst_idx", {27'h0, dump_idx}, 32'h0);
        check("mid_rst_busy", {31'h0, dump_busy}, 32'h0);
        rs1 = 5'd1;
        rs2 = 5'd2;
        #1;
        check("mid_rst_x1", RU_rs1, model[1]);
        check("mid_rst_x2", RU_rs2, 32'h0000_1000);
        rs1 = 5'd31;
        #1;
        check("mid_rst_x31", RU_rs1, 32'h0);
        dump_ready = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        check("post_rst_idle", {31'h0, dump_valid}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
